// File: rtl/mxv_pkg.sv
// rtl/mxv_pkg.sv - shared constants and types for the MxV result transmit path
//
// Contents:
//   HDR, END, CMD_RESULT  frame marker bytes
//   tx_state_e            result-transmit sequencer state encoding
//   frame_bytes()         total bytes per frame for a given element count/width
// Configuration macro: MXV_TX_CHECKSUM_EN (adds a checksum byte before END)
package mxv_pkg;

  localparam logic [7:0] HDR        = 8'hFE;
  localparam logic [7:0] END        = 8'hEF;
  localparam logic [7:0] CMD_RESULT = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } tx_state_e;

  // Header, length, command and END framing bytes, plus the optional checksum.
  function automatic int frame_bytes(input int n, input int dw);
`ifdef MXV_TX_CHECKSUM_EN
    return n * (dw / 8) + 5;
`else
    return n * (dw / 8) + 4;
`endif
  endfunction

endpackage

// File: rtl/mxv_tx_byte_mux.sv
// rtl/mxv_tx_byte_mux.sv - selects the frame byte offered to the UART
//
// Ports:
//   active_i  in   a byte is being offered; output forced to 0x00 otherwise
//   idx_i     in   frame byte index
//   snap_i    in   captured result vector, element i at [i*DW +: DW]
//   csum_i    in   running checksum (only with MXV_TX_CHECKSUM_EN)
//   byte_o    out  byte at idx_i: HDR, length, CMD_RESULT, data, [checksum], END
module mxv_tx_byte_mux
  import mxv_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic            active_i,
  input  logic [IW-1:0]   idx_i,
  input  logic [N*DW-1:0] snap_i,
`ifdef MXV_TX_CHECKSUM_EN
  input  logic [7:0]      csum_i,
`endif
  output logic [7:0]      byte_o
);

  localparam int BPE = DW / 8;
  localparam int NB  = frame_bytes(N, DW);

  always_comb begin
    byte_o = 8'h00;
    if (active_i) begin
      if (idx_i == IW'(0)) begin
        byte_o = HDR;
      end else if (idx_i == IW'(1)) begin
        byte_o = 8'(N * BPE);
      end else if (idx_i == IW'(2)) begin
        byte_o = CMD_RESULT;
      end else if (idx_i == IW'(NB - 1)) begin
        byte_o = END;
`ifdef MXV_TX_CHECKSUM_EN
      end else if (idx_i == IW'(NB - 2)) begin
        byte_o = csum_i;
`endif
      end else begin
        // Data bytes: element 0 first, most significant byte of each element first.
        for (int e = 0; e < N; e++) begin
          for (int b = 0; b < BPE; b++) begin
            if (idx_i == IW'(3 + e * BPE + b)) begin
              byte_o = snap_i[e * DW + (BPE - 1 - b) * 8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/mxv_result_tx_sequencer.sv
// rtl/mxv_result_tx_sequencer.sv - serializes the MxV result vector into a UART frame
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   enb               transmit enable (level) from the control unit
//   sync_rst          synchronous clear: abort frame, clear done flag
//   result_data       packed results, element i at [i*DW +: DW]
//   tx_ready          UART idle/ready
//   tx_start          one-cycle load pulse to the UART
//   tx_data           byte offered to the UART
//   flag_finish_send  frame complete, held until sync_rst
//   frame_idx         index of the byte currently offered
// Configuration macro: MXV_TX_CHECKSUM_EN (XOR checksum byte before END)
module mxv_result_tx_sequencer
  import mxv_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 16,
  localparam int NB = frame_bytes(N, DW),
  localparam int IW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enb,
  input  logic            sync_rst,
  input  logic [N*DW-1:0] result_data,
  input  logic            tx_ready,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic            flag_finish_send,
  output logic [IW-1:0]   frame_idx
);

  tx_state_e         state_q;
  logic [IW-1:0]     idx_q;
  logic [N*DW-1:0]   snap_q;
  logic              flag_q;
  logic              active;

`ifdef MXV_TX_CHECKSUM_EN
  logic [7:0]        csum_q;
  logic [7:0]        csum_d;

  // Length, command and data bytes feed the checksum; HDR, checksum and END do not.
  always_comb begin
    csum_d = csum_q;
    if (idx_q >= IW'(1) && idx_q <= IW'(NB - 3)) begin
      csum_d = csum_q ^ tx_data;
    end
  end
`endif

  assign active = (state_q == S_SEND) || (state_q == S_WAIT_ACK) ||
                  (state_q == S_WAIT_DONE);

  mxv_tx_byte_mux #(
    .N  (N),
    .DW (DW),
    .IW (IW)
  ) u_byte_mux (
    .active_i (active),
    .idx_i    (idx_q),
    .snap_i   (snap_q),
`ifdef MXV_TX_CHECKSUM_EN
    .csum_i   (csum_q),
`endif
    .byte_o   (tx_data)
  );

  // The pulse is issued in the SEND cycle itself so the UART sees it the cycle
  // SEND is entered; SEND always leaves after one pulse, so pulses never abut.
  assign tx_start         = (state_q == S_SEND) && tx_ready && !sync_rst;
  assign flag_finish_send = flag_q;
  assign frame_idx        = idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      flag_q  <= 1'b0;
`ifdef MXV_TX_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else if (sync_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enb && !flag_q) state_q <= S_LOAD;
        end
        S_LOAD: begin
          snap_q  <= result_data;
          idx_q   <= '0;
`ifdef MXV_TX_CHECKSUM_EN
          csum_q  <= 8'h00;
`endif
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
`ifdef MXV_TX_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            state_q <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (!tx_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (idx_q == IW'(NB - 1)) begin
              flag_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_SEND;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
